// File: rtl/serial_subtractor.sv
// Digit-serial subtractor: computes a - b - borrow_in DIGIT bits per cycle,
// LSB digit first, and reports the final borrow and signed overflow.

module serial_subtractor_digit #(
  parameter int DIGIT = 2
) (
  input  logic [DIGIT-1:0] a,
  input  logic [DIGIT-1:0] b,
  input  logic             bin,
  output logic [DIGIT-1:0] d,
  output logic             bout
);
  logic [DIGIT:0] r;

  // The extension bit of the widened difference is the borrow out of the slice.
  assign r    = {1'b0, a} - {1'b0, b} - {{DIGIT{1'b0}}, bin};
  assign d    = r[DIGIT-1:0];
  assign bout = r[DIGIT];
endmodule

module serial_subtractor #(
  parameter int WIDTH = 8,
  parameter int DIGIT = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             borrow_in,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             borrow_out,
  output logic             ovf
);
  localparam int N  = WIDTH / DIGIT;
  localparam int CW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state;
  logic [WIDTH-1:0] a_q, b_q;
  logic             a_msb, b_msb;
  logic             brw;
  logic [CW-1:0]    cnt;
  logic [DIGIT-1:0] d_k;
  logic             brw_k;

  // Operands shift right each RUN cycle so the current digit is always at bit 0.
  serial_subtractor_digit #(.DIGIT(DIGIT)) u_digit (
    .a    (a_q[DIGIT-1:0]),
    .b    (b_q[DIGIT-1:0]),
    .bin  (brw),
    .d    (d_k),
    .bout (brw_k)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      busy       <= 1'b0;
      done       <= 1'b0;
      diff       <= '0;
      borrow_out <= 1'b0;
      ovf        <= 1'b0;
      a_q        <= '0;
      b_q        <= '0;
      a_msb      <= 1'b0;
      b_msb      <= 1'b0;
      brw        <= 1'b0;
      cnt        <= '0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            a_q   <= a;
            b_q   <= b;
            a_msb <= a[WIDTH-1];
            b_msb <= b[WIDTH-1];
            brw   <= borrow_in;
            cnt   <= '0;
            diff  <= '0;
            busy  <= 1'b1;
            state <= RUN;
          end
        end
        RUN: begin
          a_q <= a_q >> DIGIT;
          b_q <= b_q >> DIGIT;
          brw <= brw_k;
          cnt <= cnt + 1'b1;
          diff[int'(cnt)*DIGIT +: DIGIT] <= d_k;
          if (cnt == CW'(N - 1)) begin
            // The last slice's top bit is the result MSB used for overflow.
            borrow_out <= brw_k;
            ovf        <= (a_msb ^ b_msb) & (d_k[DIGIT-1] ^ a_msb);
            done       <= 1'b1;
            state      <= DONE;
          end
        end
        DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_serial_subtractor.sv
// Bench for serial_subtractor: directed vectors, control corner cases,
// and DIGIT sweeps checked against an arithmetic reference model.

module tb_serial_subtractor;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic       bi = 1'b0;
  logic [7:0] a = '0, b = '0;
  logic       busy, done, bo, ovf;
  logic [7:0] diff;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct packed {logic [7:0] d; logic bo; logic ov;} res_t;
  res_t sbq[$];
  res_t swq[$];

  always #5 clk = ~clk;

  serial_subtractor #(.WIDTH(8), .DIGIT(2)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b), .borrow_in(bi),
    .busy(busy), .done(done), .diff(diff), .borrow_out(bo), .ovf(ovf)
  );

  // DIGIT sweep at WIDTH=8: DIGIT = 1, 2, 4, 8
  logic       sst = 1'b0, sbi = 1'b0;
  logic [7:0] sa = '0, sb = '0;
  logic [7:0] sw_diff [4];
  logic       sw_busy [4], sw_done [4], sw_bo [4], sw_ov [4];
  for (genvar g = 0; g < 4; g++) begin : g_sw
    serial_subtractor #(.WIDTH(8), .DIGIT(1 << g)) u (
      .clk(clk), .rst_n(rst_n), .start(sst), .a(sa), .b(sb), .borrow_in(sbi),
      .busy(sw_busy[g]), .done(sw_done[g]), .diff(sw_diff[g]),
      .borrow_out(sw_bo[g]), .ovf(sw_ov[g])
    );
  end

  // Exhaustive WIDTH=4: DIGIT = 1, 2, 4
  logic       xst = 1'b0, xbi = 1'b0;
  logic [3:0] xa = '0, xb = '0;
  logic [3:0] x_diff [3];
  logic       x_busy [3], x_done [3], x_bo [3], x_ov [3];
  for (genvar g = 0; g < 3; g++) begin : g_x
    serial_subtractor #(.WIDTH(4), .DIGIT(1 << g)) u (
      .clk(clk), .rst_n(rst_n), .start(xst), .a(xa), .b(xb), .borrow_in(xbi),
      .busy(x_busy[g]), .done(x_done[g]), .diff(x_diff[g]),
      .borrow_out(x_bo[g]), .ovf(x_ov[g])
    );
  end

  function automatic res_t model(input logic [7:0] x, input logic [7:0] y, input logic c);
    logic [8:0] f;
    res_t r;
    f    = {1'b0, x} - {1'b0, y} - {8'd0, c};
    r.d  = f[7:0];
    r.bo = f[8];
    r.ov = (x[7] ^ y[7]) & (f[7] ^ x[7]);
    return r;
  endfunction

  // Drives one operation on the main DUT; lat = edges after the accept edge
  // until done is seen (-1 on timeout), bcy = cycles with busy high.
  task automatic run_op(input logic [7:0] ta, input logic [7:0] tb_, input logic tbi,
                        output int lat, output int bcy);
    @(negedge clk);
    a = ta; b = tb_; bi = tbi; start = 1'b1;
    sbq.push_back(model(ta, tb_, tbi));
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    lat = -1;
    bcy = busy ? 1 : 0;
    for (int e = 1; e <= 40; e++) begin
      @(posedge clk);
      @(negedge clk);
      if (busy) bcy++;
      if (done) begin lat = e; break; end
    end
  endtask

  task automatic test_reset();
    #2;
    n_cmp++;
    if ({busy, done, diff, bo, ovf} !== 12'h000) begin
      n_bad++; $display("FAIL reset_outputs: got %h want 000", {busy, done, diff, bo, ovf});
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    n_cmp++;
    if ({busy, done} !== 2'b00) begin
      n_bad++; $display("FAIL reset_idle: got %b want 00", {busy, done});
    end
  endtask

  task automatic test_basic();
    int lat, bcy;
    res_t exp;
    run_op(8'd5, 8'd3, 1'b0, lat, bcy);
    exp = sbq.pop_front();
    n_cmp++;
    if (lat !== 4) begin n_bad++; $display("FAIL basic_latency: got %0d want 4", lat); end
    n_cmp++;
    if (bcy !== 5) begin n_bad++; $display("FAIL basic_busy_cycles: got %0d want 5", bcy); end
    n_cmp++;
    if ({diff, bo, ovf} !== {8'h02, 1'b0, 1'b0}) begin
      n_bad++; $display("FAIL basic_result: got %h/%b/%b want 02/0/0", diff, bo, ovf);
    end
    n_cmp++;
    if ({diff, bo, ovf} !== exp) begin
      n_bad++; $display("FAIL basic_scoreboard: got %h want %h", {diff, bo, ovf}, exp);
    end
    @(negedge clk);
    n_cmp++;
    if ({busy, done} !== 2'b00) begin
      n_bad++; $display("FAIL basic_done_pulse: got %b want 00", {busy, done});
    end
    repeat (3) @(negedge clk);
    n_cmp++;
    if ({diff, bo, ovf} !== exp) begin
      n_bad++; $display("FAIL basic_hold: got %h want %h", {diff, bo, ovf}, exp);
    end
  endtask

  task automatic test_borrow();
    int lat, bcy;
    res_t exp;
    run_op(8'd3, 8'd5, 1'b0, lat, bcy);
    exp = sbq.pop_front();
    n_cmp++;
    if ({diff, bo, ovf} !== {8'hFE, 1'b1, 1'b0} || {diff, bo, ovf} !== exp) begin
      n_bad++; $display("FAIL borrow_3m5: got %h/%b/%b want fe/1/0", diff, bo, ovf);
    end
    run_op(8'h00, 8'h00, 1'b1, lat, bcy);
    exp = sbq.pop_front();
    n_cmp++;
    if ({diff, bo, ovf} !== {8'hFF, 1'b1, 1'b0} || {diff, bo, ovf} !== exp) begin
      n_bad++; $display("FAIL borrow_in_only: got %h/%b/%b want ff/1/0", diff, bo, ovf);
    end
  endtask

  task automatic test_overflow();
    int lat, bcy;
    res_t exp;
    run_op(8'h80, 8'h01, 1'b0, lat, bcy);
    exp = sbq.pop_front();
    n_cmp++;
    if ({diff, bo, ovf} !== {8'h7F, 1'b0, 1'b1} || {diff, bo, ovf} !== exp) begin
      n_bad++; $display("FAIL ovf_neg: got %h/%b/%b want 7f/0/1", diff, bo, ovf);
    end
    run_op(8'h7F, 8'hFF, 1'b0, lat, bcy);
    exp = sbq.pop_front();
    n_cmp++;
    if ({diff, bo, ovf} !== {8'h80, 1'b1, 1'b1} || {diff, bo, ovf} !== exp) begin
      n_bad++; $display("FAIL ovf_pos: got %h/%b/%b want 80/1/1", diff, bo, ovf);
    end
  endtask

  task automatic test_reset_midrun();
    int lat, bcy, nd;
    res_t exp;
    @(negedge clk);
    a = 8'h55; b = 8'h22; bi = 1'b0; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({busy, done, diff, bo, ovf} !== 12'h000) begin
      n_bad++; $display("FAIL midrun_reset_outputs: got %h want 000", {busy, done, diff, bo, ovf});
    end
    @(negedge clk);
    rst_n = 1'b1;
    nd = 0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (done || busy) nd++;
    end
    n_cmp++;
    if (nd !== 0) begin n_bad++; $display("FAIL midrun_no_done: got %0d want 0", nd); end
    run_op(8'd9, 8'd4, 1'b0, lat, bcy);
    exp = sbq.pop_front();
    n_cmp++;
    if (lat !== 4 || {diff, bo, ovf} !== {8'h05, 1'b0, 1'b0} || {diff, bo, ovf} !== exp) begin
      n_bad++; $display("FAIL midrun_restart: got lat %0d %h/%b/%b want lat 4 05/0/0", lat, diff, bo, ovf);
    end
  endtask

  task automatic test_start_ignored();
    int nd, lat;
    logic [9:0] got;
    res_t exp;
    @(negedge clk);
    a = 8'h40; b = 8'h13; bi = 1'b0; start = 1'b1;
    sbq.push_back(model(8'h40, 8'h13, 1'b0));
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    a = 8'hFF; b = 8'h01; bi = 1'b1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    a = 8'h00; b = 8'hC3;
    nd = 0; lat = -1; got = '0;
    for (int e = 3; e <= 16; e++) begin
      @(negedge clk);
      if (done) begin
        nd++;
        if (lat < 0) begin lat = e; got = {diff, bo, ovf}; end
      end
    end
    exp = sbq.pop_front();
    n_cmp++;
    if (nd !== 1) begin n_bad++; $display("FAIL ignored_done_count: got %0d want 1", nd); end
    n_cmp++;
    if (lat !== 4 || got !== exp) begin
      n_bad++; $display("FAIL ignored_result: got lat %0d %h want lat 4 %h", lat, got, exp);
    end
  endtask

  task automatic test_back_to_back();
    int got, pushed, last;
    logic [7:0] ta, tb_;
    logic tbi;
    res_t exp;
    got = 0; pushed = 0; last = -1;
    @(negedge clk);
    for (int c = 0; c < 100 && got < 6; c++) begin
      if (!busy && !done && pushed < 6) begin
        ta = 8'($urandom); tb_ = 8'($urandom); tbi = 1'($urandom);
        a = ta; b = tb_; bi = tbi; start = 1'b1;
        sbq.push_back(model(ta, tb_, tbi));
        pushed++;
      end
      if (done) begin
        exp = sbq.pop_front();
        n_cmp++;
        if ({diff, bo, ovf} !== exp) begin
          n_bad++; $display("FAIL b2b_result%0d: got %h want %h", got, {diff, bo, ovf}, exp);
        end
        if (last >= 0) begin
          n_cmp++;
          if (c - last !== 6) begin
            n_bad++; $display("FAIL b2b_interval%0d: got %0d want 6", got, c - last);
          end
        end
        last = c;
        got++;
        if (got == 6) start = 1'b0;
      end
      @(negedge clk);
    end
    start = 1'b0;
    n_cmp++;
    if (got !== 6 || sbq.size() !== 0) begin
      n_bad++; $display("FAIL b2b_count: got %0d results %0d pending want 6/0", got, sbq.size());
    end
  endtask

  task automatic test_sweep();
    logic [7:0] corner [7];
    logic [7:0] ta, tb_;
    logic tbi;
    int lat [4];
    logic [9:0] got [4];
    res_t exp;
    corner = '{8'h00, 8'h01, 8'h7F, 8'h80, 8'hFF, 8'h55, 8'hAA};
    for (int v = 0; v < 300; v++) begin
      if (v < 98) begin
        ta = corner[v / 14]; tb_ = corner[(v / 2) % 7]; tbi = v[0];
      end else begin
        ta = 8'($urandom); tb_ = 8'($urandom); tbi = 1'($urandom);
      end
      @(negedge clk);
      sa = ta; sb = tb_; sbi = tbi; sst = 1'b1;
      swq.push_back(model(ta, tb_, tbi));
      @(posedge clk);
      @(negedge clk);
      sst = 1'b0;
      for (int g = 0; g < 4; g++) begin lat[g] = -1; got[g] = '0; end
      for (int e = 1; e <= 11; e++) begin
        @(posedge clk);
        @(negedge clk);
        for (int g = 0; g < 4; g++)
          if (sw_done[g] && lat[g] < 0) begin
            lat[g] = e; got[g] = {sw_diff[g], sw_bo[g], sw_ov[g]};
          end
      end
      exp = swq.pop_front();
      for (int g = 0; g < 4; g++) begin
        n_cmp++;
        if (lat[g] !== (8 >> g) || got[g] !== exp) begin
          n_bad++;
          $display("FAIL sweep_d%0d %h-%h-%b: got lat %0d %h want lat %0d %h",
                   1 << g, ta, tb_, tbi, lat[g], got[g], 8 >> g, exp);
        end
      end
    end
  endtask

  task automatic test_exhaustive4();
    int lat [3];
    logic [5:0] got [3];
    logic [4:0] f;
    logic [5:0] exp;
    for (int v = 0; v < 512; v++) begin
      @(negedge clk);
      xa = 4'(v >> 5); xb = 4'(v >> 1); xbi = 1'(v);
      f = {1'b0, xa} - {1'b0, xb} - {4'd0, xbi};
      exp = {f[3:0], f[4], (xa[3] ^ xb[3]) & (f[3] ^ xa[3])};
      xst = 1'b1;
      @(posedge clk);
      @(negedge clk);
      xst = 1'b0;
      for (int g = 0; g < 3; g++) begin lat[g] = -1; got[g] = '0; end
      for (int e = 1; e <= 6; e++) begin
        @(posedge clk);
        @(negedge clk);
        for (int g = 0; g < 3; g++)
          if (x_done[g] && lat[g] < 0) begin
            lat[g] = e; got[g] = {x_diff[g], x_bo[g], x_ov[g]};
          end
      end
      for (int g = 0; g < 3; g++) begin
        n_cmp++;
        if (lat[g] !== (4 >> g) || got[g] !== exp) begin
          n_bad++;
          $display("FAIL exh4_d%0d %h-%h-%b: got lat %0d %h want lat %0d %h",
                   1 << g, xa, xb, xbi, lat[g], got[g], 4 >> g, exp);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_borrow();
    test_overflow();
    test_reset_midrun();
    test_start_ignored();
    test_back_to_back();
    test_sweep();
    test_exhaustive4();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
endmodule
